// File: rtl/sound_pkg.sv
// Shared definitions for the sound mixer: FSM states, default register
// addresses and the NR52 bit layout.
package sound_pkg;

    typedef enum logic [1:0] {
        MIX_IDLE,
        MIX_ACCUM,
        MIX_SCALE,
        MIX_OUT
    } mix_state_t;

    localparam logic [15:0] NR50_ADDR_DEF = 16'hFF24;
    localparam logic [15:0] NR51_ADDR_DEF = 16'hFF25;
    localparam logic [15:0] NR52_ADDR_DEF = 16'hFF26;

    // NR52 bits 6:4 always read as 1; only the power bit is stored.
    localparam logic [7:0] NR52_CONST_BITS = 8'h70;
    localparam logic [7:0] NR52_WMASK      = 8'h80;

endpackage

// File: rtl/sound_ioreg.sv
// Single bus-mapped 8-bit register with address decode, write mask and
// synchronous clear; read data is muxed by the parent using rd_sel.
module sound_ioreg #(
    parameter logic [15:0] ADDR  = 16'h0000,
    parameter logic [7:0]  WMASK = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        we,
    input  logic        re,
    input  logic        clr,
    output logic [7:0]  q,
    output logic        rd_sel
);

    logic hit;

    assign hit    = (addr == ADDR);
    assign rd_sel = re && hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (we && hit) begin
            q <= (wdata & WMASK) | (q & ~WMASK);
        end
    end

endmodule

// File: rtl/sound_mixer_n.sv
// N-channel stereo mixer: per-channel pan (NR51), per-side volume (NR50)
// and master power (NR52), one channel accumulated per clock.
module sound_mixer_n
    import sound_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned SAMPLE_W  = 20,
    parameter int unsigned OUT_W     = 20,
    parameter logic [15:0] NR50_ADDR = NR50_ADDR_DEF,
    parameter logic [15:0] NR51_ADDR = NR51_ADDR_DEF,
    parameter logic [15:0] NR52_ADDR = NR52_ADDR_DEF
) (
    input  logic                         I_CLK,
    input  logic                         I_RESET,
    input  logic                         I_STROBE,
    input  logic [NUM_CH*SAMPLE_W-1:0]   I_CH_SAMPLES,
    input  logic [NUM_CH-1:0]            I_CH_ON,
    input  logic [15:0]                  I_IOREG_ADDR,
    inout  logic [7:0]                   IO_IOREG_DATA,
    input  logic                         I_IOREG_RE_L,
    input  logic                         I_IOREG_WE_L,
    output logic [OUT_W-1:0]             O_SO1,
    output logic [OUT_W-1:0]             O_SO2,
    output logic                         O_VALID,
    output logic                         O_BUSY,
    output logic                         O_OVERRUN
);

    localparam int unsigned ACC_W  = SAMPLE_W + 2;
    localparam int unsigned PROD_W = ACC_W + 4;
    localparam int unsigned SAT_W  = (PROD_W > OUT_W) ? PROD_W : OUT_W;
    localparam logic [1:0]  LAST_IDX = 2'(NUM_CH - 1);

    logic       wr_en, rd_en, power, clr_vol;
    logic [7:0] nr50_q, nr51_q, nr52_q, rd_data;
    logic       sel50, sel51, sel52;
    logic [3:0] on_pad;
    logic [4*SAMPLE_W-1:0] samples_pad;

    assign wr_en   = !I_IOREG_WE_L;
    assign rd_en   = !I_IOREG_RE_L;
    assign power   = nr52_q[7];
    assign clr_vol = wr_en && (I_IOREG_ADDR == NR52_ADDR) && !IO_IOREG_DATA[7];

    sound_ioreg #(.ADDR(NR50_ADDR), .WMASK(8'hFF)) u_nr50 (
        .clk(I_CLK), .rst(I_RESET), .addr(I_IOREG_ADDR), .wdata(IO_IOREG_DATA),
        .we(wr_en && power), .re(rd_en), .clr(clr_vol), .q(nr50_q), .rd_sel(sel50)
    );

    sound_ioreg #(.ADDR(NR51_ADDR), .WMASK(8'hFF)) u_nr51 (
        .clk(I_CLK), .rst(I_RESET), .addr(I_IOREG_ADDR), .wdata(IO_IOREG_DATA),
        .we(wr_en && power), .re(rd_en), .clr(clr_vol), .q(nr51_q), .rd_sel(sel51)
    );

    sound_ioreg #(.ADDR(NR52_ADDR), .WMASK(NR52_WMASK)) u_nr52 (
        .clk(I_CLK), .rst(I_RESET), .addr(I_IOREG_ADDR), .wdata(IO_IOREG_DATA),
        .we(wr_en), .re(rd_en), .clr(1'b0), .q(nr52_q), .rd_sel(sel52)
    );

    always_comb begin
        on_pad                               = '0;
        on_pad[NUM_CH-1:0]                   = I_CH_ON;
        samples_pad                          = '0;
        samples_pad[NUM_CH*SAMPLE_W-1:0]     = I_CH_SAMPLES;
    end

    // Register values are read before the clock edge, so a same-cycle write returns old data.
    always_comb begin
        rd_data = '0;
        if (sel50) rd_data = power ? nr50_q : '0;
        if (sel51) rd_data = power ? nr51_q : '0;
        if (sel52) rd_data = nr52_q | NR52_CONST_BITS | {4'b0000, on_pad};
    end

    assign IO_IOREG_DATA = (sel50 || sel51 || sel52) ? rd_data : 'z;

    mix_state_t state, state_next;
    logic [1:0]            idx;
    logic [ACC_W-1:0]      acc1, acc2;
    logic [4*SAMPLE_W-1:0] samp_q;
    logic [3:0]            on_q;
    logic [7:0]            vol_q, pan_q;
    logic                  pwr_q;

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) state <= MIX_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            MIX_IDLE:  if (I_STROBE) state_next = MIX_ACCUM;
            MIX_ACCUM: if (idx == LAST_IDX) state_next = MIX_SCALE;
            MIX_SCALE: state_next = MIX_OUT;
            MIX_OUT:   state_next = MIX_IDLE;
            default:   state_next = MIX_IDLE;
        endcase
    end

    assign O_BUSY    = (state != MIX_IDLE);
    assign O_VALID   = (state == MIX_OUT);
    assign O_OVERRUN = I_STROBE && O_BUSY;

    logic [SAMPLE_W-1:0] cur_samp;
    logic [ACC_W-1:0]    add1, add2;
    logic [PROD_W-1:0]   prod1, prod2;
    logic [SAT_W-1:0]    shr1, shr2;
    logic [OUT_W-1:0]    sat1, sat2;

    assign cur_samp = samp_q[idx*SAMPLE_W +: SAMPLE_W];
    assign add1 = (on_q[idx] && pan_q[{1'b0, idx}]) ? ACC_W'(cur_samp) : '0;
    assign add2 = (on_q[idx] && pan_q[{1'b1, idx}]) ? ACC_W'(cur_samp) : '0;

    assign prod1 = PROD_W'(acc1) * PROD_W'({1'b0, vol_q[2:0]} + 4'd1);
    assign prod2 = PROD_W'(acc2) * PROD_W'({1'b0, vol_q[6:4]} + 4'd1);
    assign shr1  = SAT_W'(prod1 >> 3);
    assign shr2  = SAT_W'(prod2 >> 3);
    assign sat1  = (shr1 > SAT_W'({OUT_W{1'b1}})) ? '1 : OUT_W'(shr1);
    assign sat2  = (shr2 > SAT_W'({OUT_W{1'b1}})) ? '1 : OUT_W'(shr2);

    // Outputs load at the SCALE->OUT edge so they are valid during the OUT cycle.
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            idx    <= '0;
            acc1   <= '0;
            acc2   <= '0;
            samp_q <= '0;
            on_q   <= '0;
            vol_q  <= '0;
            pan_q  <= '0;
            pwr_q  <= 1'b0;
            O_SO1  <= '0;
            O_SO2  <= '0;
        end else begin
            case (state)
                MIX_IDLE: begin
                    if (I_STROBE) begin
                        samp_q <= samples_pad;
                        on_q   <= on_pad;
                        vol_q  <= nr50_q;
                        pan_q  <= nr51_q;
                        pwr_q  <= power;
                        acc1   <= '0;
                        acc2   <= '0;
                        idx    <= '0;
                    end
                end
                MIX_ACCUM: begin
                    acc1 <= acc1 + add1;
                    acc2 <= acc2 + add2;
                    idx  <= (idx == LAST_IDX) ? '0 : idx + 2'd1;
                end
                MIX_SCALE: begin
                    O_SO1 <= (vol_q[3] && pwr_q) ? sat1 : '0;
                    O_SO2 <= (vol_q[7] && pwr_q) ? sat2 : '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sound_mixer_n.sv
// Directed bench for sound_mixer_n with a cycle-level reference model.
module tb_sound_mixer_n;

    localparam int NCH = 4;
    localparam int LAT = NCH + 2;

    logic        clk = 1'b0;
    logic        rst, strobe, re_l, we_l, drv_en;
    logic [79:0] ch_samples;
    logic [3:0]  ch_on;
    logic [15:0] addr;
    logic [7:0]  drv;
    wire  [7:0]  bus;
    logic [19:0] so1, so2;
    logic        valid, busy, overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    assign bus = drv_en ? drv : 8'bz;

    sound_mixer_n #(
        .NUM_CH(4), .SAMPLE_W(20), .OUT_W(20),
        .NR50_ADDR(16'hFF24), .NR51_ADDR(16'hFF25), .NR52_ADDR(16'hFF26)
    ) dut (
        .I_CLK(clk), .I_RESET(rst), .I_STROBE(strobe),
        .I_CH_SAMPLES(ch_samples), .I_CH_ON(ch_on),
        .I_IOREG_ADDR(addr), .IO_IOREG_DATA(bus),
        .I_IOREG_RE_L(re_l), .I_IOREG_WE_L(we_l),
        .O_SO1(so1), .O_SO2(so2), .O_VALID(valid),
        .O_BUSY(busy), .O_OVERRUN(overrun)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference mix from the register semantics: sum panned active channels,
    // scale by (vol+1)/8, clamp to 20 bits, gate by side enable and power.
    function automatic void mix_model(input logic [79:0] s, input logic [3:0] on,
                                      input logic [7:0] pan, input logic [7:0] vol,
                                      input logic pwr, output longint o1, output longint o2);
        longint sum1 = 0;
        longint sum2 = 0;
        for (int ch = 0; ch < 4; ch++) begin
            if (on[ch] && pan[ch])     sum1 += longint'(s[ch*20 +: 20]);
            if (on[ch] && pan[ch + 4]) sum2 += longint'(s[ch*20 +: 20]);
        end
        o1 = sum1 * (longint'(vol[2:0]) + 1) / 8;
        o2 = sum2 * (longint'(vol[6:4]) + 1) / 8;
        if (o1 > 64'd1048575) o1 = 1048575;
        if (o2 > 64'd1048575) o2 = 1048575;
        if (!(vol[3] && pwr)) o1 = 0;
        if (!(vol[7] && pwr)) o2 = 0;
    endfunction

    int         left = 0;
    logic [7:0] m50 = '0, m51 = '0;
    logic       mpwr = 1'b0;
    longint     m_so1 = 0, m_so2 = 0, p_so1 = 0, p_so2 = 0;
    logic       e_busy, e_valid, e_ovr;

    always begin
        @(negedge clk);
        #4;
        if (rst) begin
            left = 0; m_so1 = 0; m_so2 = 0; m50 = '0; m51 = '0; mpwr = 1'b0;
            e_busy = 1'b0; e_valid = 1'b0; e_ovr = 1'b0;
        end else begin
            if (left > 0) begin
                left--;
                e_busy  = 1'b1;
                e_valid = (left == 0);
            end else begin
                e_busy  = 1'b0;
                e_valid = 1'b0;
            end
            e_ovr = strobe && e_busy;
            if (strobe && !e_busy) begin
                mix_model(ch_samples, ch_on, m51, m50, mpwr, p_so1, p_so2);
                left = LAT;
            end
            if (e_valid) begin
                m_so1 = p_so1;
                m_so2 = p_so2;
            end
        end
        check("mdl_busy", busy, e_busy);
        check("mdl_valid", valid, e_valid);
        check("mdl_overrun", overrun, e_ovr);
        check("mdl_so1", so1, m_so1);
        check("mdl_so2", so2, m_so2);
        if (!rst && !we_l) begin
            case (addr)
                16'hFF26: begin
                    mpwr = bus[7];
                    if (!bus[7]) begin m50 = '0; m51 = '0; end
                end
                16'hFF24: if (mpwr) m50 = bus;
                16'hFF25: if (mpwr) m51 = bus;
                default: ;
            endcase
        end
    end

    task automatic wr_reg(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; drv = d; drv_en = 1'b1; we_l = 1'b0;
        @(negedge clk);
        we_l = 1'b1; drv_en = 1'b0;
    endtask

    task automatic rd_reg(input logic [15:0] a, input logic [7:0] exp, input string name);
        @(negedge clk);
        addr = a; re_l = 1'b0;
        #2;
        check(name, bus, exp);
        re_l = 1'b1;
    endtask

    // Returns in the OUT cycle (just after the edge that raised O_VALID).
    task automatic run_mix(input logic [19:0] e1, input logic [19:0] e2, input string name);
        int n = 0;
        @(negedge clk);
        strobe = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) strobe = 1'b0;
            if (valid) begin n = i; break; end
        end
        check({name, "_latency"}, n, LAT);
        check({name, "_so1"}, so1, e1);
        check({name, "_so2"}, so2, e2);
    endtask

    task automatic count_valid(input int cyc, output int n);
        n = 0;
        repeat (cyc) begin
            @(negedge clk);
            #1;
            if (valid) n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: no finish within time limit");
        $fatal(1, "watchdog expired");
    end

    int nv;
    logic [19:0] c1, c2;

    initial begin
        rst = 1'b1; strobe = 1'b0; ch_samples = '0; ch_on = '0;
        addr = '0; re_l = 1'b1; we_l = 1'b1; drv = '0; drv_en = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_so1", so1, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;

        rd_reg(16'hFF26, 8'h70, "rd_nr52_reset");
        rd_reg(16'hFF24, 8'h00, "rd_nr50_reset");
        rd_reg(16'hFF25, 8'h00, "rd_nr51_reset");

        wr_reg(16'hFF26, 8'h80);
        wr_reg(16'hFF25, 8'h11);
        wr_reg(16'hFF24, 8'hFF);
        ch_samples = {60'h0, 20'h10000};
        ch_on = 4'hF;
        rd_reg(16'hFF26, 8'hFF, "rd_nr52_on");
        rd_reg(16'hFF24, 8'hFF, "rd_nr50_on");
        run_mix(20'h10000, 20'h10000, "basic");

        wr_reg(16'hFF24, 8'h3B);
        run_mix(20'h08000, 20'h00000, "vol_3b");

        ch_samples = {4{20'hFFFFF}};
        wr_reg(16'hFF25, 8'hFF);
        wr_reg(16'hFF24, 8'hFF);
        run_mix(20'hFFFFF, 20'hFFFFF, "saturate");

        ch_samples = {20'h04000, 20'h03000, 20'h02000, 20'h01000};
        ch_on = 4'b1011;
        wr_reg(16'hFF25, 8'h5A);
        wr_reg(16'hFF24, 8'h9D);
        run_mix(20'h04800, 20'h00400, "pan_mix");
        strobe = 1'b1;
        #1;
        check("out_cycle_overrun", overrun, 1);
        @(negedge clk);
        strobe = 1'b0;
        count_valid(10, nv);
        check("out_cycle_no_mix", nv, 0);

        ch_samples = {60'h0, 20'h10000};
        ch_on = 4'hF;
        wr_reg(16'hFF25, 8'h11);
        wr_reg(16'hFF24, 8'hFF);
        @(negedge clk);
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        addr = 16'hFF25; drv = 8'h00; drv_en = 1'b1; we_l = 1'b0;
        @(negedge clk);
        we_l = 1'b1; drv_en = 1'b0; strobe = 1'b1;
        #1;
        check("ovr_pulse", overrun, 1);
        @(negedge clk);
        strobe = 1'b0;
        nv = 0; c1 = '0; c2 = '0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (valid) begin nv++; c1 = so1; c2 = so2; end
        end
        check("ovr_valid_count", nv, 1);
        check("ovr_so1", c1, 20'h10000);
        check("ovr_so2", c2, 20'h10000);
        rd_reg(16'hFF25, 8'h00, "rd_nr51_after_ovr");

        wr_reg(16'hFF26, 8'h00);
        wr_reg(16'hFF25, 8'hFF);
        rd_reg(16'hFF25, 8'h00, "rd_nr51_poweroff");
        rd_reg(16'hFF24, 8'h00, "rd_nr50_poweroff");
        run_mix(20'h0, 20'h0, "poweroff");

        wr_reg(16'hFF26, 8'h80);
        rd_reg(16'hFF24, 8'h00, "rd_nr50_cleared");
        wr_reg(16'hFF25, 8'h11);
        wr_reg(16'hFF24, 8'hFF);
        @(negedge clk);
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_valid", valid, 0);
        check("abort_so1", so1, 0);
        check("abort_so2", so2, 0);
        @(negedge clk);
        rst = 1'b0;
        count_valid(10, nv);
        check("abort_no_valid", nv, 0);
        rd_reg(16'hFF26, 8'h7F, "rd_nr52_after_rst");

        run_mix(20'h0, 20'h0, "first_after_rst");
        wr_reg(16'hFF26, 8'h80);
        wr_reg(16'hFF25, 8'h11);
        wr_reg(16'hFF24, 8'hFF);
        run_mix(20'h10000, 20'h10000, "basic_again");

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sound_mixer_n.md
SOUND_MIXER_N -- requirements
Module: sound_mixer_n

Interface
REQ-001 Parameters SHALL be as follows, one per line (name, default, meaning):
- NUM_CH, 4, channel count, legal range 1..4.
- SAMPLE_W, 20, unsigned channel sample width.
- OUT_W, 20, output sample width.
- NR50_ADDR, 16'hFF24, volume register address.
- NR51_ADDR, 16'hFF25, pan register address.
- NR52_ADDR, 16'hFF26, power/status register address.

REQ-002 Ports SHALL be as follows, one per line (name, direction, width, meaning):
- I_CLK, in, 1, single clock.
- I_RESET, in, 1, asynchronous active-high reset.
- I_STROBE, in, 1, one-cycle sample request, already in the I_CLK domain.
- I_CH_SAMPLES, in, NUM_CH*SAMPLE_W, packed channel samples, channel 0 in the LSBs.
- I_CH_ON, in, NUM_CH, per-channel active flags.
- I_IOREG_ADDR, in, 16, CPU register address.
- IO_IOREG_DATA, inout, 8, CPU register data.
- I_IOREG_RE_L, in, 1, active-low read.
- I_IOREG_WE_L, in, 1, active-low write.
- O_SO1, out, OUT_W, left output sample.
- O_SO2, out, OUT_W, right output sample.
- O_VALID, out, 1, one-cycle pulse when O_SO1/O_SO2 update.
- O_BUSY, out, 1, high while a mix is in progress.
- O_OVERRUN, out, 1, one-cycle pulse when a strobe is dropped.

REQ-003 The block SHALL use one clock, I_CLK, and an asynchronous, active-high reset, I_RESET.

Function
REQ-004 Register write: when I_IOREG_WE_L=0 and I_IOREG_ADDR matches, the addressed register SHALL take IO_IOREG_DATA on the next I_CLK edge.

REQ-005 Register read: when I_IOREG_RE_L=0 and the address matches, the block SHALL drive IO_IOREG_DATA combinationally; otherwise IO_IOREG_DATA SHALL be high-Z.

REQ-006 NR52 read SHALL return {power, 3'b111, I_CH_ON zero-padded to 4 bits}; only NR52 bit7 (power) SHALL be writable.

REQ-007 While power=0:
- NR50 and NR51 SHALL read 0x00.
- Writes to NR50 and NR51 SHALL be ignored.
- Writing power 1->0 SHALL clear NR50 and NR51.

REQ-008 The mix FSM SHALL have four states: IDLE, ACCUM, SCALE, OUT.

REQ-009 IDLE + I_STROBE SHALL:
- snapshot I_CH_SAMPLES, I_CH_ON, NR50, NR51 and power;
- clear acc1 and acc2;
- set idx to 0;
- go to ACCUM.
Register writes during the mix SHALL NOT affect the current result.

REQ-010 ACCUM SHALL process one channel per cycle, idx 0..NUM_CH-1:
- acc1 += sample[idx] if NR51[idx] and on[idx];
- acc2 += sample[idx] if NR51[idx+4] and on[idx].
After idx=NUM_CH-1 the FSM SHALL go to SCALE.

REQ-011 acc1 and acc2 SHALL be SAMPLE_W+2 bits wide and SHALL never overflow.

REQ-012 SCALE SHALL compute, per side:
- s1 = (acc1*(NR50[2:0]+1))>>3 and s2 = (acc2*(NR50[6:4]+1))>>3, in full precision;
- then saturate each result to 2^OUT_W-1.

REQ-013 OUT SHALL:
- register O_SO1 = s1 if NR50[3] and power, else 0;
- register O_SO2 = s2 if NR50[7] and power, else 0;
- pulse O_VALID for one cycle;
- return to IDLE.

REQ-014 Latency: a strobe in cycle t SHALL produce O_VALID in cycle t+NUM_CH+2.

REQ-015 O_SO1 and O_SO2 SHALL hold their values between O_VALID pulses.

REQ-016 O_BUSY SHALL be 1 in every state except IDLE.

REQ-017 An I_STROBE while O_BUSY=1 SHALL be ignored and SHALL pulse O_OVERRUN for one cycle; the mix in progress SHALL continue unaffected.

REQ-018 An I_STROBE in the same cycle as the return to IDLE (the OUT cycle) SHALL count as an overrun and SHALL NOT start a new mix.

REQ-019 A register write and a read to the same address in the same cycle SHALL return the old value.

Reset
REQ-020 I_RESET SHALL asynchronously force the following: FSM to IDLE; NR50, NR51 and power to 0; acc1, acc2 and idx to 0; O_SO1, O_SO2, O_VALID, O_BUSY and O_OVERRUN to 0.

REQ-021 A reset during ACCUM or SCALE SHALL abort the mix, and no O_VALID SHALL follow the abort.

REQ-022 The first strobe after reset deassertion SHALL be accepted.

Structure
REQ-023 A shared package sound_pkg SHALL hold:
- the FSM state encodings;
- the default register addresses (taken from memdef.vh);
- the NR52 constant-bits mask.

REQ-024 One sub-module, sound_ioreg, SHALL implement a single bus-mapped 8-bit register with read-enable, write-enable and clear inputs; it SHALL be instantiated once each for NR50, NR51 and NR52.

Verification (NUM_CH=4, SAMPLE_W=OUT_W=20)
REQ-025 Reset, with I_CH_ON=0, then read FF26 -> 0x70; read FF24 -> 0x00; read FF25 -> 0x00.

REQ-026 Write NR52=0x80, NR51=0x11, NR50=0xFF; ch0=0x10000, other channels 0, all on; strobe -> O_VALID exactly 6 cycles later with O_SO1=O_SO2=0x10000.

REQ-027 NR50=0x3B, same samples as REQ-026 -> O_SO1=0x08000, O_SO2=0.

REQ-028 All four channels=0xFFFFF, NR51=0xFF, NR50=0xFF -> O_SO1=O_SO2=0xFFFFF (saturated).

REQ-029 Strobe again 2 cycles after the first, and write NR51=0x00 during ACCUM -> one O_OVERRUN pulse, exactly one O_VALID, result equals REQ-026.

REQ-030 Write NR52=0x00, then NR51=0xFF -> FF25 reads 0x00; strobe -> O_VALID with O_SO1=O_SO2=0. Assert I_RESET mid-ACCUM -> no O_VALID, all outputs 0.
